// File: rtl/scie_fir_pkg.sv
// Shared constants and types for the SCIE five-tap FIR custom-instruction unit.
package scie_fir_pkg;

    localparam int XLEN   = 32;
    localparam int TAPS   = 5;
    localparam int DATA_W = 16;
    localparam int FRAC   = 16;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 35;
    localparam int IDX_W  = 3;

    localparam logic [6:0] OP_SETC = 7'h0B;
    localparam logic [6:0] OP_PUSH = 7'h2B;
    localparam logic [6:0] OP_READ = 7'h5B;

    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [DATA_W-1:0] coef_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/scie_fir_mac.sv
// Registered per-tap products followed by a combinational full-precision adder tree.
module scie_fir_mac
    import scie_fir_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [TAPS-1:0][DATA_W-1:0]   coef_i,
    input  logic [TAPS-1:0][DATA_W-1:0]   x_i,
    output logic [ACC_W-1:0]              sum_o
);

    prod_t prod_q [TAPS];
    prod_t prod_d [TAPS];

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            assign prod_d[gi] = PROD_W'(coef_i[gi]) * PROD_W'(x_i[gi]);

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    prod_q[gi] <= '0;
                end else begin
                    prod_q[gi] <= prod_d[gi];
                end
            end
        end
    endgenerate

    // 35 bits holds five full-scale 32-bit products without overflow.
    always_comb begin
        sum_o = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_o = sum_o + ACC_W'(prod_q[k]);
        end
    end

endmodule

// File: rtl/scie_fir_pipelined.sv
// SCIE-style FIR unit: opcode decode, coefficient file, delay line and registered result.
module scie_fir_pipelined
    import scie_fir_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] io_insn,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    input  logic            io_valid,
    output logic [XLEN-1:0] io_rd
);

    logic [TAPS-1:0][DATA_W-1:0] coef_q, coef_d;
    logic [TAPS-1:0][DATA_W-1:0] x_q, x_d;
    logic [XLEN-1:0]             rd_q, rd_d;
    acc_t                        sum;

    logic [6:0]       opcode;
    logic [IDX_W-1:0] idx;
    sample_t          operand;
    logic             unused_bits;

    assign opcode      = io_insn[6:0];
    assign idx         = io_rs2[IDX_W-1:0];
    assign operand     = io_rs1[DATA_W-1:0];
    assign unused_bits = ^{io_insn[XLEN-1:7], io_rs1[XLEN-1:DATA_W], io_rs2[XLEN-1:IDX_W]};

    always_comb begin
        coef_d = coef_q;
        x_d    = x_q;
        rd_d   = rd_q;
        if (io_valid) begin
            case (opcode)
                OP_SETC: begin
                    if (idx < IDX_W'(TAPS)) begin
                        coef_d[idx] = operand;
                    end
                end
                OP_PUSH: x_d  = {x_q[TAPS-2:0], operand};
                // The sum reflects state committed two edges ago; READ right after an update sees old data.
                OP_READ: rd_d = XLEN'(sum >> FRAC);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            coef_q <= '0;
            x_q    <= '0;
            rd_q   <= '0;
        end else begin
            coef_q <= coef_d;
            x_q    <= x_d;
            rd_q   <= rd_d;
        end
    end

    scie_fir_mac u_mac (
        .clock  (clock),
        .reset  (reset),
        .coef_i (coef_q),
        .x_i    (x_q),
        .sum_o  (sum)
    );

    assign io_rd = rd_q;

endmodule

// File: tb/tb_scie_fir_pipelined.sv
// Scoreboard bench for scie_fir_pipelined: READ results queued at issue, compared after the edge.
module tb_scie_fir_pipelined;

    localparam logic [6:0] OP_SETC = 7'h0B;
    localparam logic [6:0] OP_PUSH = 7'h2B;
    localparam logic [6:0] OP_READ = 7'h5B;
    localparam logic [6:0] OP_BAD  = 7'h33;

    logic        clock;
    logic        reset;
    logic [31:0] io_insn;
    logic [31:0] io_rs1;
    logic [31:0] io_rs2;
    logic        io_valid;
    logic [31:0] io_rd;

    int total;
    int bad;

    longint unsigned coef_m [5];
    longint unsigned x_m    [5];
    longint unsigned prod_m [5];
    logic [31:0]     rd_m;
    logic [31:0]     exp_q [$];

    scie_fir_pipelined dut (
        .clock    (clock),
        .reset    (reset),
        .io_insn  (io_insn),
        .io_rs1   (io_rs1),
        .io_rs2   (io_rs2),
        .io_valid (io_valid),
        .io_rd    (io_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 5; k++) begin
            coef_m[k] = 0;
            x_m[k]    = 0;
            prod_m[k] = 0;
        end
        rd_m = '0;
        exp_q.delete();
    endtask

    // Reference behaviour for one clock edge with the given instruction.
    task automatic model_step(input logic v, input logic [6:0] op, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] override,
                              input bit use_override);
        longint unsigned s;
        longint unsigned np [5];
        s = 0;
        for (int k = 0; k < 5; k++) s += prod_m[k];
        for (int k = 0; k < 5; k++) np[k] = coef_m[k] * x_m[k];
        if (v) begin
            if (op == OP_READ) begin
                rd_m = 32'(s >> 16);
                exp_q.push_back(use_override ? override : rd_m);
            end else if (op == OP_SETC) begin
                if (rs2[2:0] < 3'd5) coef_m[rs2[2:0]] = {48'd0, rs1[15:0]};
            end else if (op == OP_PUSH) begin
                for (int k = 4; k > 0; k--) x_m[k] = x_m[k-1];
                x_m[0] = {48'd0, rs1[15:0]};
            end
        end
        for (int k = 0; k < 5; k++) prod_m[k] = np[k];
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic exec(input string tag, input logic v, input logic [6:0] op,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] override = '0, input bit use_override = 1'b0);
        logic [31:0] exp;
        io_valid = v;
        io_insn  = {25'h1ABCDE0 >> 0, op} ^ {25'h0, 7'h0} | 32'hFFFF_FF80 & {$urandom, 7'h0};
        io_insn[6:0] = op;
        io_rs1   = rs1 | ({$urandom} << 16);
        io_rs2   = rs2;
        model_step(v, op, rs1, rs2, override, use_override);
        @(posedge clock);
        @(negedge clock);
        if (v && op == OP_READ) begin
            if (exp_q.size() == 0) begin
                check_eq({tag, "_noexp"}, 32'd1, 32'd0);
            end else begin
                exp = exp_q.pop_front();
                check_eq(tag, io_rd, exp);
                $display("read %s: rd=%0d exp=%0d", tag, io_rd, exp);
            end
        end
    endtask

    task automatic setc(input int idx, input int val);
        exec("setc", 1'b1, OP_SETC, 32'(val), 32'(idx));
    endtask

    task automatic idle();
        exec("idle", 1'b0, 7'h00, 32'd0, 32'd0);
    endtask

    task automatic push_read(input string tag, input int val);
        exec("push", 1'b1, OP_PUSH, 32'(val), 32'($urandom));
        idle();
        exec(tag, 1'b1, OP_READ, 32'd0, 32'($urandom));
    endtask

    task automatic push_read_k(input string tag, input int val, input int k);
        exec("push", 1'b1, OP_PUSH, 32'(val), 32'($urandom));
        idle();
        exec(tag, 1'b1, OP_READ, 32'd0, 32'd0, 32'(k), 1'b1);
    endtask

    initial begin
        int cset [5];
        total = 0;
        bad   = 0;
        reset    = 1'b0;
        io_valid = 1'b0;
        io_insn  = '0;
        io_rs1   = '0;
        io_rs2   = '0;
        model_clear();
        repeat (3) @(negedge clock);
        check_eq("reset_rd", io_rd, 32'd0);
        reset = 1'b1;

        exec("rd_after_reset", 1'b1, OP_READ, 32'd0, 32'd0, 32'd0, 1'b1);

        cset = '{52345, 51674, 64687, 11306, 42746};
        for (int i = 0; i < 5; i++) setc(i, cset[i]);
        push_read_k("acc1", 28315, 22615);
        push_read_k("acc2", 33076, 48744);
        push_read_k("acc3", 27880, 76296);
        push_read("acc4", 63880);
        push_read("acc5", 38666);
        push_read("drop6", 1234);

        // Ignored operations: invalid SETC, out-of-range SETC, unknown opcode.
        exec("inv_setc", 1'b0, OP_SETC, 32'd7, 32'd0);
        exec("inv_push", 1'b0, OP_PUSH, 32'd9999, 32'd0);
        exec("inv_read", 1'b0, OP_READ, 32'd0, 32'd0);
        check_eq("hold_invalid", io_rd, rd_m);
        for (int i = 5; i < 8; i++) setc(i, 60000);
        idle();
        idle();
        exec("ignored_read", 1'b1, OP_READ, 32'd0, 32'd0);
        exec("bad_op", 1'b1, OP_BAD, 32'd12345, 32'd1);
        check_eq("hold_badop", io_rd, rd_m);
        idle();
        idle();
        exec("badop_read", 1'b1, OP_READ, 32'd0, 32'd0);

        // Single tap with truncation.
        setc(0, 65535);
        for (int i = 1; i < 5; i++) setc(i, 0);
        push_read_k("single_tap", 1000, 999);

        // Hazard: READ right after PUSH still sees the previous product set.
        exec("push_hz", 1'b1, OP_PUSH, 32'd2000, 32'd0);
        exec("hazard_old", 1'b1, OP_READ, 32'd0, 32'd0, 32'd999, 1'b1);
        exec("hazard_new", 1'b1, OP_READ, 32'd0, 32'd0, 32'd1999, 1'b1);

        // Asynchronous reset mid-sequence.
        setc(1, 40000);
        exec("push_pre", 1'b1, OP_PUSH, 32'd3000, 32'd0);
        #2 reset = 1'b0;
        #1 check_eq("async_reset_rd", io_rd, 32'd0);
        model_clear();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        exec("post_reset_rd", 1'b1, OP_READ, 32'd0, 32'd0, 32'd0, 1'b1);
        push_read_k("post_reset_push", 5000, 0);
        setc(2, 30000);
        idle();
        idle();
        exec("post_reset_coef", 1'b1, OP_READ, 32'd0, 32'd0, 32'd0, 1'b1);
        push_read("post_reset_rebuild", 7000);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
